uart_tx_fifo: RTL

- Parametrised UART transmitter with an integrated transmit FIFO.
- Supports a configurable character width and per-frame line format: parity and stop bits.
- Accepts writes while a frame is in flight. Queued characters are sent back-to-back; nothing is silently overwritten.
- Sits between a host/bus write port and the serial pin; intended to replace the single-buffer transmitter.

---
 rtl/uart_tx_fifo.sv | 288 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with an integrated circular transmit FIFO.
// Characters are framed as START, DATA (LSB first), optional PARITY, STOP1 and
// optional STOP2; queued characters follow each other with no idle gap.
// Build option: define UART_TX_FIFO_BREAK_EN to add the break_i input and
// line-break generation (low line while break_i is high, then one mark bit).
module uart_tx_fifo #(
  parameter int DATA_WIDTH    = 8,
  parameter int FIFO_DEPTH    = 4,
  parameter int DIVIDER_WIDTH = 16
) (
  input  logic                          clock_i,
  input  logic                          reset_n_i,
  input  logic                          write_i,
  input  logic [DATA_WIDTH-1:0]         data_i,
  input  logic                          two_stop_bits_i,
  input  logic                          parity_bit_i,
  input  logic                          parity_even_i,
  input  logic [DIVIDER_WIDTH-1:0]      clock_divider_i,
  input  logic                          clear_overflow_i,
`ifdef UART_TX_FIFO_BREAK_EN
  input  logic                          break_i,
`endif
  output logic                          serial_o,
  output logic                          busy_o,
  output logic                          full_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic                          overflow_o
);

  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = ADDR_W + 1;
  localparam int BIT_W  = $clog2(DATA_WIDTH);

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  // Frame sequencer states.
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP1  = 3'd4;
  localparam logic [2:0] S_STOP2  = 3'd5;
`ifdef UART_TX_FIFO_BREAK_EN
  localparam logic [2:0] S_BREAK  = 3'd6;
  localparam logic [2:0] S_MARK   = 3'd7;
`endif

  // FIFO storage and bookkeeping.
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0]     wr_ptr_q;
  logic [ADDR_W-1:0]     rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic                  overflow_q;

  // Sequencer registers.
  logic [2:0]               state_q,    state_d;
  logic [DATA_WIDTH-1:0]    shift_q,    shift_d;
  logic [BIT_W-1:0]         bit_cnt_q,  bit_cnt_d;
  logic [DIVIDER_WIDTH-1:0] div_cnt_q,  div_cnt_d;
  logic [DIVIDER_WIDTH-1:0] div_lat_q,  div_lat_d;
  logic                     par_en_q,   par_en_d;
  logic                     par_val_q,  par_val_d;
  logic                     two_stop_q, two_stop_d;
  logic                     serial_q,   serial_d;

  logic                  push;
  logic                  pop;
  logic                  fifo_nonempty;
  logic                  bit_end;
  logic                  bit_timed;
  logic                  frame_done;
  logic [DATA_WIDTH-1:0] head_data;

  assign full_o        = (count_q == DEPTH_C);
  assign fifo_nonempty = (count_q != '0);
  assign push          = write_i & ~full_o;
  assign head_data     = mem_q[rd_ptr_q];
  assign bit_end       = (div_cnt_q == '0);

`ifdef UART_TX_FIFO_BREAK_EN
  assign bit_timed = (state_q != S_IDLE) && (state_q != S_BREAK);
`else
  assign bit_timed = (state_q != S_IDLE);
`endif

  // FIFO data array: written on accepted pushes only, no reset needed.
  always_ff @(posedge clock_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop keep the count.
  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky overflow flag; a new overflow takes priority over a clear.
  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      overflow_q <= 1'b0;
    end else if (write_i && full_o) begin
      overflow_q <= 1'b1;
    end else if (clear_overflow_i) begin
      overflow_q <= 1'b0;
    end
  end

  // Next-state logic of the frame sequencer, bit timer and line format latch.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    div_cnt_d  = div_cnt_q;
    div_lat_d  = div_lat_q;
    par_en_d   = par_en_q;
    par_val_d  = par_val_q;
    two_stop_d = two_stop_q;
    frame_done = 1'b0;
    pop        = 1'b0;

    // Every timed bit runs divider+1 clocks, then the counter reloads.
    if (bit_timed) begin
      if (bit_end) begin
        div_cnt_d = div_lat_q;
      end else begin
        div_cnt_d = div_cnt_q - 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (fifo_nonempty) begin
          pop = 1'b1;
        end
`ifdef UART_TX_FIFO_BREAK_EN
        // A break request holds the queue until it is released.
        if (break_i) begin
          pop     = 1'b0;
          state_d = S_BREAK;
        end
`endif
      end
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          bit_cnt_d = LAST_BIT;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == '0) begin
            state_d = par_en_q ? S_PARITY : S_STOP1;
          end else begin
            bit_cnt_d = bit_cnt_q - 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP1;
        end
      end
      S_STOP1: begin
        if (bit_end) begin
          if (two_stop_q) begin
            state_d = S_STOP2;
          end else begin
            frame_done = 1'b1;
          end
        end
      end
      S_STOP2: begin
        if (bit_end) begin
          frame_done = 1'b1;
        end
      end
`ifdef UART_TX_FIFO_BREAK_EN
      S_BREAK: begin
        // Releasing the break starts a one-bit mark at the current divider.
        if (!break_i) begin
          state_d   = S_MARK;
          div_cnt_d = clock_divider_i;
          div_lat_d = clock_divider_i;
        end
      end
      S_MARK: begin
        if (bit_end) begin
          frame_done = 1'b1;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // End of the last stop bit: chain straight into the next frame if queued.
    if (frame_done) begin
      if (fifo_nonempty) begin
        pop = 1'b1;
      end else begin
        state_d = S_IDLE;
      end
    end

    // Loading a frame latches its character and line format for its lifetime.
    if (pop) begin
      state_d    = S_START;
      shift_d    = head_data;
      div_cnt_d  = clock_divider_i;
      div_lat_d  = clock_divider_i;
      par_en_d   = parity_bit_i;
      par_val_d  = (^head_data) ^ ~parity_even_i;
      two_stop_d = two_stop_bits_i;
    end
  end

  // Line level implied by the current sequencer state.
  always_comb begin
    serial_d = 1'b1;
    case (state_q)
      S_START:  serial_d = 1'b0;
      S_DATA:   serial_d = shift_q[0];
      S_PARITY: serial_d = par_val_q;
`ifdef UART_TX_FIFO_BREAK_EN
      S_BREAK:  serial_d = 1'b0;
`endif
      default:  serial_d = 1'b1;
    endcase
  end

  // Sequencer state registers; reset aborts any frame in flight.
  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      div_cnt_q  <= '0;
      div_lat_q  <= '0;
      par_en_q   <= 1'b0;
      par_val_q  <= 1'b0;
      two_stop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      div_cnt_q  <= div_cnt_d;
      div_lat_q  <= div_lat_d;
      par_en_q   <= par_en_d;
      par_val_q  <= par_val_d;
      two_stop_q <= two_stop_d;
    end
  end

  // Registered TX pin so the line never glitches; idles high.
  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      serial_q <= 1'b1;
    end else begin
      serial_q <= serial_d;
    end
  end

  assign serial_o     = serial_q;
  assign busy_o       = (state_q != S_IDLE) | fifo_nonempty;
  assign fifo_count_o = count_q;
  assign overflow_o   = overflow_q;

endmodule
